// File: rtl/csel_adder_pipe.sv
// Pipelined carry-select adder/subtractor: one GRP-bit group resolves per stage,
// with valid/ready streaming and a single global advance enable.
module csel_adder_pipe #(
   parameter int WIDTH = 16,
   parameter int GRP   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NGRP = WIDTH / GRP;
   localparam int LAST = NGRP - 1;

   // Ripple adder over one group; returns {carry_out, sum}.
   function automatic logic [GRP:0] grp_add(input logic [GRP-1:0] x,
                                            input logic [GRP-1:0] y,
                                            input logic           ci);
      logic           c;
      logic [GRP-1:0] s;
      c = ci;
      s = {GRP{1'b0}};
      for (int i = 0; i < GRP; i++) begin
         s[i] = x[i] ^ y[i] ^ c;
         c    = (x[i] & y[i]) | (x[i] & c) | (y[i] & c);
      end
      return {c, s};
   endfunction

   logic [WIDTH-1:0] b_eff_s;
   logic             c_eff_s;
   logic             adv_s;
   logic             ovf_r;

   assign b_eff_s = sub ? ~b : b;
   assign c_eff_s = sub ? ~cin : cin;

   for (genvar k = 0; k < NGRP; k++) begin : g_stg
      // OW: operand bits still unresolved after this stage; RW: resolved sum bits held
      localparam int OW = WIDTH - (k + 1) * GRP;
      localparam int RW = (k + 1) * GRP;

      logic [GRP-1:0] x_s;
      logic [GRP-1:0] y_s;
      logic           v_s;
      logic [GRP:0]   res_s;
      logic [RW-1:0]  s_nxt_s;
      logic           v_r;
      logic           c_r;
      logic [RW-1:0]  s_r;

      if (k == 0) begin : g_first
         assign x_s     = a[GRP-1:0];
         assign y_s     = b_eff_s[GRP-1:0];
         assign v_s     = in_valid;
         assign res_s   = grp_add(x_s, y_s, c_eff_s);
         assign s_nxt_s = res_s[GRP-1:0];
      end else begin : g_next
         logic [GRP:0] res0_s;
         logic [GRP:0] res1_s;
         assign x_s     = g_stg[k-1].g_hold.ha_r[GRP-1:0];
         assign y_s     = g_stg[k-1].g_hold.hb_r[GRP-1:0];
         assign v_s     = g_stg[k-1].v_r;
         assign res0_s  = grp_add(x_s, y_s, 1'b0);
         assign res1_s  = grp_add(x_s, y_s, 1'b1);
         assign res_s   = g_stg[k-1].c_r ? res1_s : res0_s;
         assign s_nxt_s = {res_s[GRP-1:0], g_stg[k-1].s_r};
      end

      if (OW > 0) begin : g_hold
         logic [OW-1:0] ha_s;
         logic [OW-1:0] hb_s;
         logic [OW-1:0] ha_r;
         logic [OW-1:0] hb_r;

         if (k == 0) begin : g_src0
            assign ha_s = a[WIDTH-1:GRP];
            assign hb_s = b_eff_s[WIDTH-1:GRP];
         end else begin : g_srck
            assign ha_s = g_stg[k-1].g_hold.ha_r[OW+GRP-1:GRP];
            assign hb_s = g_stg[k-1].g_hold.hb_r[OW+GRP-1:GRP];
         end

         // Forward the operand bits later stages still have to add.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               ha_r <= {OW{1'b0}};
               hb_r <= {OW{1'b0}};
            end else if (adv_s) begin
               ha_r <= ha_s;
               hb_r <= hb_s;
            end else begin
               ha_r <= ha_r;
               hb_r <= hb_r;
            end
         end
      end

      // Stage valid, group carry and resolved sum bits; all hold when the pipe stalls.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v_r <= 1'b0;
            c_r <= 1'b0;
            s_r <= {RW{1'b0}};
         end else if (adv_s) begin
            v_r <= v_s;
            c_r <= res_s[GRP];
            s_r <= s_nxt_s;
         end else begin
            v_r <= v_r;
            c_r <= c_r;
            s_r <= s_r;
         end
      end
   end

   // Signed overflow is resolved alongside the MSB group so it leaves with its beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_r <= 1'b0;
      end else if (adv_s) begin
         ovf_r <= (g_stg[LAST].x_s[GRP-1] == g_stg[LAST].y_s[GRP-1]) &&
                  (g_stg[LAST].res_s[GRP-1] != g_stg[LAST].x_s[GRP-1]);
      end else begin
         ovf_r <= ovf_r;
      end
   end

   assign adv_s     = !g_stg[LAST].v_r || out_ready;
   assign in_ready  = adv_s;
   assign out_valid = g_stg[LAST].v_r;
   assign sum       = g_stg[LAST].s_r;
   assign cout      = g_stg[LAST].c_r;
   assign ovf       = ovf_r;

endmodule

// File: tb/tb_csel_adder_pipe.sv
// Scoreboard bench for csel_adder_pipe at 16/4, 32/8, 12/3 and 8/8, all fed from
// one shared stimulus stream; each instance keeps its own expected-result queue.
module tb_csel_adder_pipe;

   localparam int W   [4] = '{16, 32, 12, 8};
   localparam int LAT [4] = '{4, 4, 4, 1};

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic        cin = 1'b0;
   logic        sub = 1'b0;
   logic [31:0] a = 32'd0;
   logic [31:0] b = 32'd0;

   logic [3:0]  ir;
   logic [3:0]  ov;
   logic [3:0]  co;
   logic [3:0]  of;
   logic [15:0] s0;
   logic [31:0] s1;
   logic [11:0] s2;
   logic [7:0]  s3;

   int          ncmp = 0;
   int          nfail = 0;
   logic [33:0] sbq [4][$];

   always #5 clk = ~clk;

   csel_adder_pipe #(.WIDTH(16), .GRP(4)) u0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
      .a(a[15:0]), .b(b[15:0]), .cin(cin), .sub(sub), .out_valid(ov[0]),
      .out_ready(out_ready), .sum(s0), .cout(co[0]), .ovf(of[0]));
   csel_adder_pipe #(.WIDTH(32), .GRP(8)) u1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
      .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(ov[1]),
      .out_ready(out_ready), .sum(s1), .cout(co[1]), .ovf(of[1]));
   csel_adder_pipe #(.WIDTH(12), .GRP(3)) u2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]),
      .a(a[11:0]), .b(b[11:0]), .cin(cin), .sub(sub), .out_valid(ov[2]),
      .out_ready(out_ready), .sum(s2), .cout(co[2]), .ovf(of[2]));
   csel_adder_pipe #(.WIDTH(8), .GRP(8)) u3 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[3]),
      .a(a[7:0]), .b(b[7:0]), .cin(cin), .sub(sub), .out_valid(ov[3]),
      .out_ready(out_ready), .sum(s3), .cout(co[3]), .ovf(of[3]));

   // Reference arithmetic at width w; returns {ovf, cout, sum}.
   function automatic logic [33:0] model(input int w, input logic [31:0] av,
                                         input logic [31:0] bv, input logic ci,
                                         input logic sb);
      logic [31:0] mask;
      logic [31:0] be;
      logic [32:0] full;
      logic        ce;
      logic        vo;
      mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      be   = (sb ? ~bv : bv) & mask;
      ce   = sb ? ~ci : ci;
      full = {1'b0, av & mask} + {1'b0, be} + {32'd0, ce};
      vo   = (av[w-1] == be[w-1]) && (full[w-1] != av[w-1]);
      return {vo, full[w], full[31:0] & mask};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Per-instance monitor, called on the falling edge ahead of the transferring rising edge.
   task automatic mon(input int k, input logic v, input logic [31:0] s,
                      input logic c, input logic o, input logic r);
      logic [33:0] e;
      check($sformatf("rdy_d%0d", k), 64'(r), 64'(!(v && !out_ready)));
      if (v) begin
         if (sbq[k].size() == 0) begin
            check($sformatf("spurious_d%0d", k), 64'(v), 64'd0);
         end else begin
            e = sbq[k][0];
            check($sformatf("out_d%0d", k), {30'd0, o, c, s}, {30'd0, e});
            if (out_ready) void'(sbq[k].pop_front());
         end
      end
      if (in_valid && r && rst_n) sbq[k].push_back(model(W[k], a, b, cin, sub));
   endtask

   always @(negedge clk) begin
      mon(0, ov[0], {16'd0, s0}, co[0], of[0], ir[0]);
      mon(1, ov[1], s1,          co[1], of[1], ir[1]);
      mon(2, ov[2], {20'd0, s2}, co[2], of[2], ir[2]);
      mon(3, ov[3], {24'd0, s3}, co[3], of[3], ir[3]);
   end

   // One beat into an empty pipe: checks per-instance latency and the 16-bit constants.
   task automatic go(input logic [31:0] av, input logic [31:0] bv, input logic ci,
                     input logic sb, input logic [17:0] exp0);
      @(posedge clk); #1;
      a = av; b = bv; cin = ci; sub = sb; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int n = 0; n < 4; n++) begin
         for (int k = 0; k < 4; k++)
            check($sformatf("lat_d%0d_n%0d", k, n), 64'(ov[k]), 64'(n == LAT[k] - 1));
         if (n == 3) check("dir16", {46'd0, of[0], co[0], s0}, {46'd0, exp0});
         if (n < 3) begin @(posedge clk); #1; end
      end
      @(posedge clk); #1;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size()) != 0 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      for (int k = 0; k < 4; k++)
         check($sformatf("drain_d%0d", k), 64'(sbq[k].size()), 64'd0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) begin
         check($sformatf("rst_vld_d%0d", k), 64'(ov[k]), 64'd0);
         check($sformatf("rst_cout_d%0d", k), 64'(co[k]), 64'd0);
         check($sformatf("rst_ovf_d%0d", k), 64'(of[k]), 64'd0);
         check($sformatf("rst_rdy_d%0d", k), 64'(ir[k]), 64'd1);
      end
      check("rst_sum", {s1, s0, s2, s3, 4'd0}, 64'd0);
      rst_n = 1'b1;

      go(32'h001F, 32'h000C, 1'b0, 1'b0, {1'b0, 1'b0, 16'h002B});
      go(32'hFFFF, 32'h0000, 1'b1, 1'b0, {1'b0, 1'b1, 16'h0000});
      go(32'h7FFF, 32'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h8000});
      go(32'h0005, 32'h0007, 1'b0, 1'b1, {1'b0, 1'b0, 16'hFFFE});
      go(32'h8000, 32'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 16'h7FFF});

      // Back-to-back streaming with out_ready held high.
      out_ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
         in_valid = 1'b1;
         for (int k = 0; k < 4; k++)
            if (i >= LAT[k]) check($sformatf("stream_vld_d%0d", k), 64'(ov[k]), 64'd1);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      drain();

      // Random backpressure; pipe fills first while the sink is stalled.
      for (int i = 0; i < 300; i++) begin
         a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = (i < 40) ? 1'b0 : 1'($urandom_range(0, 1));
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      drain();

      // Asynchronous reset with a full pipe.
      for (int i = 0; i < 4; i++) begin
         a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
         in_valid = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      check("full_before_rst", 64'(ov[0]), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < 4; k++) begin
         check($sformatf("arst_vld_d%0d", k), 64'(ov[k]), 64'd0);
         check($sformatf("arst_rdy_d%0d", k), 64'(ir[k]), 64'd1);
         sbq[k].delete();
      end
      check("arst_out16", {46'd0, of[0], co[0], s0}, 64'd0);
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      go(32'h1234, 32'h4321, 1'b0, 1'b0, {1'b0, 1'b0, 16'h5555});
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
